// File: rtl/md_unit_ctrl_if.sv
// -----------------------------------------------------------------------------
// md_unit_ctrl_if
//   Bundles the E-stage request side and the HI/LO / status side of the
//   multiply/divide sequencer so pipeline and unit share one connection.
//
//   start    : E-stage MD instruction valid this cycle (single-cycle pulse)
//   op       : 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 rsvd
//   src_a    : forwarded rs value
//   src_b    : forwarded rt value
//   md_D     : instruction in D stage is MD-class
//   hi, lo   : architectural HI / LO registers
//   busy     : multi-cycle operation in flight
//   stall_md : stall request to the hazard unit
//
//   master : pipeline side (drives the request, observes results)
//   slave  : the MD unit
// -----------------------------------------------------------------------------
interface md_unit_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_D;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_md;

    modport master (
        output start, op, src_a, src_b, md_D,
        input  hi, lo, busy, stall_md
    );

    modport slave (
        input  start, op, src_a, src_b, md_D,
        output hi, lo, busy, stall_md
    );
endinterface

// File: rtl/md_unit_ctrl.sv
// -----------------------------------------------------------------------------
// md_unit_ctrl
//   Sequences the multi-cycle multiply/divide resource in the E stage and owns
//   the HI/LO registers. An arithmetic op (MULT/MULTU/DIV/DIVU) is computed
//   from the operands present in its start cycle, held as a pending result,
//   and committed to HI/LO once a fixed latency has counted down. MTHI/MTLO
//   write HI/LO directly at the next edge. A stall request is raised while an
//   MD-class instruction sits in D and the unit is (or is about to become)
//   busy.
//
//   Ports:
//     clk   : pipeline clock, all state on rising edge
//     reset : asynchronous, active-low; clears all state immediately
//     md    : md_unit_ctrl_if.slave (request in, HI/LO + status out)
//
//   Parameters:
//     MULT_LAT : busy cycles for MULT/MULTU (1..15)
//     DIV_LAT  : busy cycles for DIV/DIVU   (1..15)
// -----------------------------------------------------------------------------
module md_unit_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic           clk,
    input  logic           reset,
    md_unit_ctrl_if.slave  md
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    md_op_e op_e;
    assign op_e = md_op_e'(md.op);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e      state_q,      state_d;
    logic [3:0]  count_q,      count_d;
    logic [31:0] pending_hi_q, pending_hi_d;
    logic [31:0] pending_lo_q, pending_lo_d;
    logic        commit_ok_q,  commit_ok_d;   // 0 for divide-by-zero
    logic [31:0] hi_q,         hi_d;
    logic [31:0] lo_q,         lo_d;

    // -------------------------------------------------------------------------
    // Arithmetic on the start-cycle operands
    // -------------------------------------------------------------------------
    logic [63:0]        a_sx, b_sx;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic [31:0]        divisor_s;
    logic [31:0]        divisor_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    always_comb begin
        // Low 64 bits of a product of sign-extended operands equal the
        // signed 32x32 product, so no signed multiplier is needed.
        a_sx   = {{32{md.src_a[31]}}, md.src_a};
        b_sx   = {{32{md.src_b[31]}}, md.src_b};
        prod_s = a_sx * b_sx;
        prod_u = {32'd0, md.src_a} * {32'd0, md.src_b};

        div_zero = (md.src_b == 32'd0);
        div_ovf  = (md.src_a == 32'h8000_0000) && (md.src_b == 32'hFFFF_FFFF);

        // Dividing by 1 instead of -1 in the overflow case yields exactly the
        // required quotient 0x80000000 and remainder 0. Dividing by 1 on a
        // zero divisor keeps the divider X-free; that result is never
        // committed.
        divisor_s = (div_zero || div_ovf) ? 32'd1 : md.src_b;
        divisor_u = div_zero ? 32'd1 : md.src_b;

        // SV signed / and % truncate toward zero; remainder takes the
        // dividend's sign.
        quot_s = $signed(md.src_a) / $signed(divisor_s);
        rem_s  = $signed(md.src_a) % $signed(divisor_s);
        quot_u = md.src_a / divisor_u;
        rem_u  = md.src_a % divisor_u;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned; that is what keeps this logic from
        // inferring latches.
        state_d      = state_q;
        count_d      = count_q;
        pending_hi_d = pending_hi_q;
        pending_lo_d = pending_lo_q;
        commit_ok_d  = commit_ok_q;
        hi_d         = hi_q;
        lo_d         = lo_q;

        unique case (state_q)
            IDLE: begin
                if (md.start) begin
                    unique case (op_e)
                        OP_MULT: begin
                            pending_hi_d = prod_s[63:32];
                            pending_lo_d = prod_s[31:0];
                            commit_ok_d  = 1'b1;
                            count_d      = 4'(MULT_LAT);
                            state_d      = RUN;
                        end
                        OP_MULTU: begin
                            pending_hi_d = prod_u[63:32];
                            pending_lo_d = prod_u[31:0];
                            commit_ok_d  = 1'b1;
                            count_d      = 4'(MULT_LAT);
                            state_d      = RUN;
                        end
                        OP_DIV: begin
                            pending_hi_d = rem_s;
                            pending_lo_d = quot_s;
                            commit_ok_d  = !div_zero;
                            count_d      = 4'(DIV_LAT);
                            state_d      = RUN;
                        end
                        OP_DIVU: begin
                            pending_hi_d = rem_u;
                            pending_lo_d = quot_u;
                            commit_ok_d  = !div_zero;
                            count_d      = 4'(DIV_LAT);
                            state_d      = RUN;
                        end
                        OP_MTHI: hi_d = md.src_a;
                        OP_MTLO: lo_d = md.src_a;
                        default: ;  // OP_NONE / OP_RSVD: no effect
                    endcase
                end
            end

            RUN: begin
                // Any start seen here is ignored: the hazard unit holds new
                // MD instructions in D until busy drops.
                if (count_q == 4'd1) begin
                    if (commit_ok_q) begin
                        hi_d = pending_hi_q;
                        lo_d = pending_lo_q;
                    end
                    count_d = 4'd0;
                    state_d = IDLE;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: the pending result is reset along with HI/LO even though it is
    // only consumed after a fresh start; this keeps the whole unit in a known
    // state out of reset and makes an abandoned operation leave no trace.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values computed above, independent of statement order.
        if (!reset) begin
            state_q      <= IDLE;
            count_q      <= 4'd0;
            pending_hi_q <= 32'd0;
            pending_lo_q <= 32'd0;
            commit_ok_q  <= 1'b0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            pending_hi_q <= pending_hi_d;
            pending_lo_q <= pending_lo_d;
            commit_ok_q  <= commit_ok_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    logic start_arith;
    assign start_arith = md.start && (md.op inside {[3'd1:3'd4]});

    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
    assign md.busy = (state_q == RUN);

    // Combinational so the D-stage instruction is held in the very cycle an
    // arithmetic op starts in E; MTHI/MTLO complete in one edge and never
    // stall.
    assign md.stall_md = md.md_D && (md.busy || start_arith);

endmodule

// File: tb/tb_md_unit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_unit_ctrl
//   Directed bench for md_unit_ctrl with hand-computed HI/LO results, busy
//   windows and stall behaviour.
// -----------------------------------------------------------------------------
module tb_md_unit_ctrl;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    md_unit_ctrl_if md_if ();

    md_unit_ctrl #(
        .MULT_LAT (5),
        .DIV_LAT  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to the next cycle: inputs are changed 1 time unit after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle t, then check busy/stall through
    // cycle t+lat and the committed HI/LO in cycle t+lat+1. Returns in cycle
    // t+lat+1 so the next op can issue back-to-back.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic md_d, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic exp_stall0;
        md_if.start = 1'b1;
        md_if.op    = op;
        md_if.src_a = a;
        md_if.src_b = b;
        md_if.md_D  = md_d;
        #1;
        exp_stall0 = md_d && (op >= 3'd1) && (op <= 3'd4);
        tests++;
        if (md_if.stall_md !== exp_stall0) begin
            fails++;
            $display("FAIL %s stall@t: got %b want %b", name, md_if.stall_md, exp_stall0);
        end
        tests++;
        if (md_if.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s busy@t: got %b want 0", name, md_if.busy);
        end
        for (int k = 1; k <= lat; k++) begin
            next_cycle();
            md_if.start = 1'b0;
            #1;
            tests++;
            if (md_if.busy !== 1'b1 || md_if.stall_md !== md_d) begin
                fails++;
                $display("FAIL %s busy/stall@t+%0d: got %b/%b want 1/%b",
                         name, k, md_if.busy, md_if.stall_md, md_d);
            end
        end
        next_cycle();
        md_if.start = 1'b0;
        #1;
        tests++;
        if (md_if.busy !== 1'b0 || md_if.stall_md !== 1'b0) begin
            fails++;
            $display("FAIL %s busy/stall@end: got %b/%b want 0/0",
                     name, md_if.busy, md_if.stall_md);
        end
        tests++;
        if (md_if.hi !== exp_hi || md_if.lo !== exp_lo) begin
            fails++;
            $display("FAIL %s hi/lo: got %h/%h want %h/%h",
                     name, md_if.hi, md_if.lo, exp_hi, exp_lo);
        end
        md_if.md_D = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        md_if.start = 1'b0;
        md_if.op    = 3'd0;
        md_if.src_a = 32'd0;
        md_if.src_b = 32'd0;
        md_if.md_D  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (md_if.hi !== 32'd0 || md_if.lo !== 32'd0 || md_if.busy !== 1'b0 ||
            md_if.stall_md !== 1'b0) begin
            fails++;
            $display("FAIL reset: got hi=%h lo=%h busy=%b stall=%b want 0/0/0/0",
                     md_if.hi, md_if.lo, md_if.busy, md_if.stall_md);
        end
        md_if.md_D = 1'b0;
        reset      = 1'b1;
        next_cycle();
    endtask

    task automatic test_mult();
        run_op("mult_neg1x2", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu_ffx2", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 5,
               32'h0000_0001, 32'hFFFF_FFFE);
    endtask

    task automatic test_div();
        run_op("div_m7d2", 3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7dm2", 3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 10,
               32'h0000_0001, 32'hFFFF_FFFD);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10,
               32'h0000_0000, 32'h8000_0000);
        run_op("divu_100d7", 3'd4, 32'd100, 32'd7, 1'b0, 10,
               32'd2, 32'd14);
    endtask

    task automatic test_div_zero();
        run_op("mthi_11", 3'd5, 32'h11, 32'h0, 1'b0, 0, 32'h11, 32'd14);
        run_op("mtlo_22", 3'd6, 32'h22, 32'h0, 1'b0, 0, 32'h11, 32'h22);
        run_op("divu_7d0", 3'd4, 32'd7, 32'd0, 1'b0, 10, 32'h11, 32'h22);
        run_op("div_5d0", 3'd3, 32'd5, 32'd0, 1'b0, 10, 32'h11, 32'h22);
        run_op("mthi_abcd", 3'd5, 32'hABCD_0000, 32'h0, 1'b0, 0,
               32'hABCD_0000, 32'h22);
    endtask

    task automatic test_stall();
        run_op("mult_stall", 3'd1, 32'd5, 32'd6, 1'b1, 5, 32'd0, 32'd30);
        run_op("mult_nostall", 3'd1, 32'd7, 32'd8, 1'b0, 5, 32'd0, 32'd56);
        run_op("mtlo_stall", 3'd6, 32'h5555, 32'h0, 1'b1, 0, 32'd0, 32'h5555);
        run_op("op7_noeffect", 3'd7, 32'h1234, 32'h9, 1'b1, 0, 32'd0, 32'h5555);
        run_op("op0_noeffect", 3'd0, 32'h4321, 32'h9, 1'b1, 0, 32'd0, 32'h5555);
    endtask

    task automatic test_reset_abort();
        md_if.start = 1'b1;
        md_if.op    = 3'd3;
        md_if.src_a = 32'd100;
        md_if.src_b = 32'd3;
        md_if.md_D  = 1'b1;
        next_cycle();
        md_if.start = 1'b0;
        repeat (3) next_cycle();
        // Cycle t+4: unit is busy; reset mid-cycle must clear outputs at once.
        tests++;
        if (md_if.busy !== 1'b1) begin
            fails++;
            $display("FAIL abort busy_before: got %b want 1", md_if.busy);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (md_if.hi !== 32'd0 || md_if.lo !== 32'd0 || md_if.busy !== 1'b0 ||
            md_if.stall_md !== 1'b0) begin
            fails++;
            $display("FAIL abort immediate: got hi=%h lo=%h busy=%b stall=%b want 0/0/0/0",
                     md_if.hi, md_if.lo, md_if.busy, md_if.stall_md);
        end
        repeat (2) next_cycle();
        reset      = 1'b1;
        md_if.md_D = 1'b0;
        for (int k = 0; k < 12; k++) begin
            next_cycle();
            tests++;
            if (md_if.busy !== 1'b0 || md_if.hi !== 32'd0 || md_if.lo !== 32'd0) begin
                fails++;
                $display("FAIL abort no_commit@%0d: got busy=%b hi=%h lo=%h want 0/0/0",
                         k, md_if.busy, md_if.hi, md_if.lo);
            end
        end
        run_op("mult_3x4", 3'd1, 32'd3, 32'd4, 1'b0, 5, 32'd0, 32'd12);
    endtask

    task automatic test_ignored_start();
        // Cycle t: MULT 0x10 * 0x20.
        md_if.start = 1'b1;
        md_if.op    = 3'd1;
        md_if.src_a = 32'h10;
        md_if.src_b = 32'h20;
        md_if.md_D  = 1'b0;
        next_cycle();
        // t+1: operands change.
        md_if.start = 1'b0;
        md_if.src_a = 32'd100;
        md_if.src_b = 32'd3;
        #1;
        tests++;
        if (md_if.busy !== 1'b1) begin
            fails++;
            $display("FAIL ignore busy@t+1: got %b want 1", md_if.busy);
        end
        next_cycle();
        // t+2: DIV start while busy must be ignored.
        md_if.start = 1'b1;
        md_if.op    = 3'd3;
        #1;
        tests++;
        if (md_if.busy !== 1'b1) begin
            fails++;
            $display("FAIL ignore busy@t+2: got %b want 1", md_if.busy);
        end
        for (int k = 3; k <= 5; k++) begin
            next_cycle();
            md_if.start = 1'b0;
            #1;
            tests++;
            if (md_if.busy !== 1'b1) begin
                fails++;
                $display("FAIL ignore busy@t+%0d: got %b want 1", k, md_if.busy);
            end
        end
        next_cycle();
        #1;
        tests++;
        if (md_if.busy !== 1'b0 || md_if.hi !== 32'd0 || md_if.lo !== 32'h200) begin
            fails++;
            $display("FAIL ignore result: got busy=%b hi=%h lo=%h want 0/00000000/00000200",
                     md_if.busy, md_if.hi, md_if.lo);
        end
        // Stay idle for a full DIV window to confirm nothing was queued.
        for (int k = 0; k < 11; k++) begin
            next_cycle();
            tests++;
            if (md_if.busy !== 1'b0 || md_if.lo !== 32'h200) begin
                fails++;
                $display("FAIL ignore idle@%0d: got busy=%b lo=%h want 0/00000200",
                         k, md_if.busy, md_if.lo);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_stall();
        test_reset_abort();
        test_ignored_start();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
